// File: rtl/gate_guard_pkg.sv
// Shared encodings for the gate guard: FSM states, fault causes and gate-vector helpers.
package gate_guard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARM   = 2'b01,
    ST_RUN   = 2'b10,
    ST_FAULT = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE  = 2'b00,
    FC_EXT   = 2'b01,
    FC_SHOOT = 2'b10
  } fault_code_e;

  localparam int unsigned NUM_GATES = 6;

  // Gate vector order is {H, L, H1, L1, H2, L2}; ARM turns on the low sides only.
  localparam logic [NUM_GATES-1:0] ARM_GATES = 6'b010101;

  function automatic logic shoot_through(input logic [NUM_GATES-1:0] g);
    return (g[5] & g[4]) | (g[3] & g[2]) | (g[1] & g[0]);
  endfunction

endpackage

// File: rtl/gate_guard_single_if.sv
// Gate request inputs and gate pin outputs of the single-phase gate guard.
interface gate_guard_single_if;
  logic h_in, l_in, h1_in, l1_in, h2_in, l2_in;
  logic H, L, H1, L1, H2, L2;

  modport master (
    output h_in, l_in, h1_in, l1_in, h2_in, l2_in,
    input  H, L, H1, L1, H2, L2
  );

  modport slave (
    input  h_in, l_in, h1_in, l1_in, h2_in, l2_in,
    output H, L, H1, L1, H2, L2
  );
endinterface

// File: rtl/gate_glitch_filter.sv
// One gate channel: input register plus a minimum-pulse-width filter applied to both edges.
module gate_glitch_filter #(
  parameter int unsigned MINPW_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_in,
  input  logic [MINPW_W-1:0] i_min_pulse,
  output logic               o_filt
);

  logic               r_in_q;
  logic               r_filt;
  logic [MINPW_W-1:0] r_cnt;

  // >= so a lowered min_pulse takes effect on a counter already past it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_q <= 1'b0;
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_in_q <= i_in;
      if (r_in_q == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt >= i_min_pulse) begin
        r_filt <= r_in_q;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + MINPW_W'(1);
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/gate_guard_single.sv
// Gate guard between the deadtime driver and the gate pins: pulse filtering, bootstrap
// precharge, and latched all-off fault handling for external and shoot-through faults.
module gate_guard_single
  import gate_guard_pkg::*;
#(
  parameter int unsigned MINPW_W  = 8,
  parameter int unsigned FLT_FILT = 4,
  parameter int unsigned ARM_CYC  = 5000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               clr_fault,
  input  logic               fault_n_in,
  input  logic [MINPW_W-1:0] min_pulse,
  gate_guard_single_if.slave gio,
  output logic               fault,
  output logic [1:0]         fault_code,
  output logic [1:0]         state
);

  localparam int unsigned ARM_W = (ARM_CYC > 1) ? $clog2(ARM_CYC) : 1;
  localparam int unsigned FLT_W = $clog2(FLT_FILT + 1);
  localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(ARM_CYC - 1);
  localparam logic [FLT_W-1:0] FLT_MAX  = FLT_W'(FLT_FILT);

  logic [NUM_GATES-1:0] w_req;
  logic [NUM_GATES-1:0] w_filt;

  assign w_req = {gio.h_in, gio.l_in, gio.h1_in, gio.l1_in, gio.h2_in, gio.l2_in};

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_filt
    gate_glitch_filter #(
      .MINPW_W(MINPW_W)
    ) u_filt (
      .clk        (clk),
      .rst        (rst),
      .i_in       (w_req[g]),
      .i_min_pulse(min_pulse),
      .o_filt     (w_filt[g])
    );
  end

  // fault_n_in is asynchronous: two-flop synchroniser, then a saturating low-level counter.
  logic [1:0]       r_fn_sync;
  logic [FLT_W-1:0] r_flt_cnt;
  logic             w_ext_flt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fn_sync <= 2'b11;
      r_flt_cnt <= '0;
    end else begin
      r_fn_sync <= {r_fn_sync[0], fault_n_in};
      if (r_fn_sync[1]) begin
        r_flt_cnt <= '0;
      end else if (r_flt_cnt != FLT_MAX) begin
        r_flt_cnt <= r_flt_cnt + FLT_W'(1);
      end
    end
  end

  assign w_ext_flt = (r_flt_cnt == FLT_MAX);

  state_e               r_state, w_state_d;
  fault_code_e          r_code, w_code_d;
  logic [ARM_W-1:0]     r_arm_cnt, w_arm_cnt_d;
  logic [NUM_GATES-1:0] r_gates, w_gates_d;
  logic                 r_fault;

  always_comb begin
    w_state_d   = r_state;
    w_code_d    = r_code;
    w_arm_cnt_d = r_arm_cnt;
    w_gates_d   = '0;

    if (w_ext_flt && (r_state != ST_FAULT)) begin
      w_state_d = ST_FAULT;
      w_code_d  = FC_EXT;
    end else if ((r_state == ST_RUN) && shoot_through(w_filt)) begin
      w_state_d = ST_FAULT;
      w_code_d  = FC_SHOOT;
    end else if (!enable && ((r_state == ST_ARM) || (r_state == ST_RUN))) begin
      w_state_d = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (enable) begin
            w_state_d   = ST_ARM;
            w_arm_cnt_d = ARM_LOAD;
          end
        end
        ST_ARM: begin
          if (r_arm_cnt == '0) w_state_d = ST_RUN;
          else                 w_arm_cnt_d = r_arm_cnt - ARM_W'(1);
        end
        ST_RUN: ;
        ST_FAULT: begin
          if (clr_fault && r_fn_sync[1]) begin
            w_state_d = ST_IDLE;
            w_code_d  = FC_NONE;
          end
        end
        default: ;
      endcase
    end

    // Decoding the next state keeps an illegal pair off the pins on the edge entering FAULT.
    case (w_state_d)
      ST_ARM:  w_gates_d = ARM_GATES;
      ST_RUN:  w_gates_d = w_filt;
      default: w_gates_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_code    <= FC_NONE;
      r_arm_cnt <= '0;
      r_gates   <= '0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_code    <= w_code_d;
      r_arm_cnt <= w_arm_cnt_d;
      r_gates   <= w_gates_d;
      r_fault   <= (w_state_d == ST_FAULT);
    end
  end

  assign gio.H      = r_gates[5];
  assign gio.L      = r_gates[4];
  assign gio.H1     = r_gates[3];
  assign gio.L1     = r_gates[2];
  assign gio.H2     = r_gates[1];
  assign gio.L2     = r_gates[0];
  assign fault      = r_fault;
  assign fault_code = r_code;
  assign state      = r_state;

endmodule

// File: tb/tb_gate_guard_single.sv
// Bench for gate_guard_single: directed scenarios plus a randomized run against a window-based model.
module tb_gate_guard_single;

  localparam int ARM_CYC = 8;
  localparam int HIST    = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       clr_fault = 1'b0;
  logic       fault_n_in = 1'b1;
  logic [7:0] min_pulse = 8'd0;
  logic       fault;
  logic [1:0] fault_code;
  logic [1:0] state;

  gate_guard_single_if gio ();

  gate_guard_single #(
    .MINPW_W (8),
    .FLT_FILT(4),
    .ARM_CYC (ARM_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .clr_fault (clr_fault),
    .fault_n_in(fault_n_in),
    .min_pulse (min_pulse),
    .gio       (gio),
    .fault     (fault),
    .fault_code(fault_code),
    .state     (state)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: raw input history per edge (newest first) and spec-level state.
  logic [5:0] x_hist[$];
  logic       f_hist[$];
  logic [5:0] m_filt;
  logic [5:0] m_gates;
  logic [1:0] m_state;
  logic [1:0] m_code;
  int         m_arm_el;

  function automatic logic [5:0] pins();
    return {gio.H, gio.L, gio.H1, gio.L1, gio.H2, gio.L2};
  endfunction

  function automatic logic [5:0] reqs();
    return {gio.h_in, gio.l_in, gio.h1_in, gio.l1_in, gio.h2_in, gio.l2_in};
  endfunction

  task automatic set_req(input logic [5:0] v);
    gio.h_in  = v[5];
    gio.l_in  = v[4];
    gio.h1_in = v[3];
    gio.l1_in = v[2];
    gio.h2_in = v[1];
    gio.l2_in = v[0];
  endtask

  function automatic void model_reset();
    x_hist.delete();
    f_hist.delete();
    for (int i = 0; i < HIST; i++) begin
      x_hist.push_back(6'b0);
      f_hist.push_back(1'b1);
    end
    m_filt   = '0;
    m_gates  = '0;
    m_state  = 2'd0;
    m_code   = 2'd0;
    m_arm_el = 0;
  endfunction

  function automatic void model_step();
    logic [5:0] nf;
    logic       ext;
    logic       shoot;
    if (rst) begin
      model_reset();
      return;
    end
    // A channel flips once its last min_pulse+1 registered samples all disagree with it.
    nf = m_filt;
    for (int c = 0; c < 6; c++) begin
      logic upd;
      upd = 1'b1;
      for (int j = 0; j <= int'(min_pulse); j++) begin
        if (x_hist[j][c] == m_filt[c]) upd = 1'b0;
      end
      if (upd) nf[c] = ~m_filt[c];
    end
    ext   = !(f_hist[2] | f_hist[3] | f_hist[4] | f_hist[5]);
    shoot = (m_filt[5] & m_filt[4]) | (m_filt[3] & m_filt[2]) | (m_filt[1] & m_filt[0]);
    if (ext && m_state != 2'd3) begin
      m_state = 2'd3;
      m_code  = 2'd1;
    end else if (m_state == 2'd2 && shoot) begin
      m_state = 2'd3;
      m_code  = 2'd2;
    end else if (!enable && (m_state == 2'd1 || m_state == 2'd2)) begin
      m_state = 2'd0;
    end else if (m_state == 2'd0 && enable) begin
      m_state  = 2'd1;
      m_arm_el = 0;
    end else if (m_state == 2'd1) begin
      if (m_arm_el == ARM_CYC - 1) m_state = 2'd2;
      else m_arm_el++;
    end else if (m_state == 2'd3 && clr_fault && f_hist[1]) begin
      m_state = 2'd0;
      m_code  = 2'd0;
    end
    m_gates = (m_state == 2'd1) ? 6'b010101 : (m_state == 2'd2) ? m_filt : 6'b0;
    x_hist.push_front(reqs());
    void'(x_hist.pop_back());
    f_hist.push_front(fault_n_in);
    void'(f_hist.pop_back());
    m_filt = nf;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    set_req(6'b0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (pins() !== 6'b0) begin errors++;
      $display("FAIL reset_gates got %b want 000000", pins()); end
    checks++; if (state !== 2'd0) begin errors++;
      $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (fault !== 1'b0) begin errors++;
      $display("FAIL reset_fault got %b want 0", fault); end
    checks++; if (fault_code !== 2'd0) begin errors++;
      $display("FAIL reset_code got %0d want 0", fault_code); end
  endtask

  task automatic test_arm();
    int n;
    min_pulse = 8'd0;
    set_req(6'b100100);
    repeat (4) tick();
    enable = 1'b1;
    tick();
    n = 0;
    while (pins() === 6'b010101 && n < 50) begin
      n++;
      tick();
    end
    checks++; if (n != ARM_CYC) begin errors++;
      $display("FAIL arm_len got %0d want %0d", n, ARM_CYC); end
    checks++; if (state !== 2'd2) begin errors++;
      $display("FAIL arm_to_run got %0d want 2", state); end
    checks++; if (pins() !== 6'b100100) begin errors++;
      $display("FAIL run_follow got %b want 100100", pins()); end
  endtask

  task automatic test_pulse_filter();
    int lens[2];
    int first;
    int width;
    lens[0] = 5;
    lens[1] = 4;
    min_pulse = 8'd4;
    set_req(6'b0);
    repeat (12) tick();
    for (int k = 0; k < 2; k++) begin
      first = -1;
      width = 0;
      gio.h_in = 1'b1;
      for (int i = 1; i <= 24; i++) begin
        tick();
        if (i == lens[k]) gio.h_in = 1'b0;
        if (gio.H === 1'b1) begin
          width++;
          if (first < 0) first = i;
        end
      end
      if (k == 0) begin
        checks++; if (first != 7) begin errors++;
          $display("FAIL pulse5_delay got %0d want 7", first); end
        checks++; if (width != 5) begin errors++;
          $display("FAIL pulse5_width got %0d want 5", width); end
      end else begin
        checks++; if (width != 0) begin errors++;
          $display("FAIL pulse4_blocked got width %0d want 0", width); end
      end
    end
  endtask

  task automatic test_shoot_through();
    logic both;
    min_pulse = 8'd0;
    set_req(6'b0);
    repeat (3) tick();
    both = 1'b0;
    gio.h_in = 1'b1;
    gio.l_in = 1'b1;
    tick();
    gio.h_in = 1'b0;
    gio.l_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (gio.H === 1'b1 && gio.L === 1'b1) both = 1'b1;
      tick();
    end
    checks++; if (both !== 1'b0) begin errors++;
      $display("FAIL shoot_pins got both_on=1 want 0"); end
    checks++; if (state !== 2'd3) begin errors++;
      $display("FAIL shoot_state got %0d want 3", state); end
    checks++; if (fault_code !== 2'd2) begin errors++;
      $display("FAIL shoot_code got %0d want 2", fault_code); end
    checks++; if (fault !== 1'b1) begin errors++;
      $display("FAIL shoot_fault got %b want 1", fault); end
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    checks++; if (state !== 2'd0) begin errors++;
      $display("FAIL shoot_clear_state got %0d want 0", state); end
    checks++; if ({fault, fault_code} !== 3'b000) begin errors++;
      $display("FAIL shoot_clear_flags got %b want 000", {fault, fault_code}); end
  endtask

  task automatic test_ext_fault();
    int n;
    enable = 1'b1;
    n = 0;
    while (state !== 2'd2 && n < 40) begin
      tick();
      n++;
    end
    checks++; if (state !== 2'd2) begin errors++;
      $display("FAIL ext_reach_run got %0d want 2", state); end
    fault_n_in = 1'b0;
    repeat (3) tick();
    fault_n_in = 1'b1;
    repeat (10) tick();
    checks++; if (state !== 2'd2) begin errors++;
      $display("FAIL ext_3cyc_ignored got %0d want 2", state); end
    fault_n_in = 1'b0;
    repeat (4) tick();
    n = 0;
    while (state !== 2'd3 && n < 10) begin
      tick();
      n++;
    end
    checks++; if (state !== 2'd3) begin errors++;
      $display("FAIL ext_4cyc_state got %0d want 3", state); end
    checks++; if (fault_code !== 2'd1) begin errors++;
      $display("FAIL ext_code got %0d want 1", fault_code); end
    checks++; if (pins() !== 6'b0) begin errors++;
      $display("FAIL ext_gates got %b want 000000", pins()); end
    clr_fault = 1'b1;
    repeat (3) tick();
    clr_fault = 1'b0;
    checks++; if (state !== 2'd3) begin errors++;
      $display("FAIL ext_clr_while_low got %0d want 3", state); end
    fault_n_in = 1'b1;
    repeat (3) tick();
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    checks++; if (state !== 2'd0) begin errors++;
      $display("FAIL ext_exit_state got %0d want 0", state); end
    checks++; if ({fault, fault_code} !== 3'b000) begin errors++;
      $display("FAIL ext_exit_flags got %b want 000", {fault, fault_code}); end
  endtask

  task automatic test_enable_and_rst();
    int n;
    min_pulse = 8'd0;
    set_req(6'b100110);
    enable = 1'b1;
    n = 0;
    while (state !== 2'd2 && n < 40) begin
      tick();
      n++;
    end
    repeat (4) tick();
    checks++; if (pins() !== 6'b100110) begin errors++;
      $display("FAIL en_run_gates got %b want 100110", pins()); end
    enable = 1'b0;
    tick();
    checks++; if (pins() !== 6'b0 || state !== 2'd0) begin errors++;
      $display("FAIL en_drop got gates %b state %0d want 000000 0", pins(), state); end
    enable = 1'b1;
    repeat (2) tick();
    checks++; if (state !== 2'd1 || pins() !== 6'b010101) begin errors++;
      $display("FAIL arm_again got gates %b state %0d want 010101 1", pins(), state); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (state !== 2'd0 || pins() !== 6'b0) begin errors++;
      $display("FAIL rst_in_arm got gates %b state %0d want 000000 0", pins(), state); end
  endtask

  task automatic test_random();
    int hold[6];
    int fn_low;
    logic [5:0] r;
    r = reqs();
    fn_low = 0;
    for (int c = 0; c < 6; c++) hold[c] = $urandom_range(1, 8);
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < 6; c++) begin
        if (hold[c] == 0) begin
          r[c] = ~r[c];
          hold[c] = $urandom_range(1, 10);
        end else begin
          hold[c]--;
        end
      end
      set_req(r);
      if (i % 64 == 0) min_pulse = 8'($urandom_range(0, 6));
      enable = ($urandom_range(0, 199) != 0);
      if (fn_low == 0 && $urandom_range(0, 99) == 0) fn_low = $urandom_range(1, 6);
      fault_n_in = (fn_low == 0);
      if (fn_low > 0) fn_low--;
      clr_fault = ($urandom_range(0, 15) == 0);
      tick();
      checks++;
      if ({pins(), state, fault, fault_code} !==
          {m_gates, m_state, (m_state == 2'd3), m_code}) begin
        errors++;
        $display("FAIL random cyc %0d got gates %b st %0d flt %b code %0d want %b %0d %b %0d",
                 i, pins(), state, fault, fault_code, m_gates, m_state, (m_state == 2'd3),
                 m_code);
      end
    end
    enable = 1'b0;
    clr_fault = 1'b0;
    fault_n_in = 1'b1;
  endtask

  initial begin
    set_req(6'b0);
    model_reset();
    test_reset();
    test_arm();
    test_pulse_filter();
    test_shoot_through();
    test_ext_fault();
    test_enable_and_rst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
